// File: rtl/reservation_station.sv
// ---------------------------------------------------------------------------
// reservation_station
//   Tomasulo-style reservation station with RS_SIZE entries. Each entry holds
//   an instruction and its two source operands, either as values (Vj/Vk) or as
//   pending producer tags (Qj/Qk). Entries wake up from the CDB broadcast, and
//   one ready entry is issued to the ALU per cycle.
//
// Ports
//   clk, rst                 clock, synchronous active-low reset
//   new_inst_in + fields     dispatcher insert (inst, imm, pc, dest, rs1/rs2)
//   cdb_valid_in/tag/value   common data bus broadcast
//   clear_in                 misprediction flush of every entry
//   full_out                 all entries busy (combinational)
//   alu_valid_out + alu_*    registered issue pulse and issued fields
//
// Handshake: new_inst_in is a one-cycle valid with no separate ready. The
// station accepts it whenever full_out is low. When full_out is high, the
// instruction is dropped; the dispatcher is expected to hold off. The ALU side
// is valid-only. alu_valid_out pulses for one cycle per issued instruction,
// and alu_* keep their last values while alu_valid_out is low.
// ---------------------------------------------------------------------------
module reservation_station #(
  parameter int RS_SIZE = 8,
  parameter int TAG_W   = 4,
  parameter int INST_W  = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              new_inst_in,
  input  logic [INST_W-1:0] inst_in,
  input  logic [31:0]       imm_in,
  input  logic [31:0]       pc_in,
  input  logic [TAG_W-1:0]  dest_in,
  input  logic              rs1_busy_in,
  input  logic [TAG_W-1:0]  rs1_tag_in,
  input  logic [31:0]       rs1_val_in,
  input  logic              rs2_busy_in,
  input  logic [TAG_W-1:0]  rs2_tag_in,
  input  logic [31:0]       rs2_val_in,
  input  logic              cdb_valid_in,
  input  logic [TAG_W-1:0]  cdb_tag_in,
  input  logic [31:0]       cdb_value_in,
  input  logic              clear_in,
  output logic              full_out,
  output logic              alu_valid_out,
  output logic [INST_W-1:0] alu_inst_out,
  output logic [31:0]       alu_op1_out,
  output logic [31:0]       alu_op2_out,
  output logic [31:0]       alu_imm_out,
  output logic [31:0]       alu_pc_out,
  output logic [TAG_W-1:0]  alu_dest_out
);

  localparam int IDX_W = (RS_SIZE > 1) ? $clog2(RS_SIZE) : 1;

  // Entry storage
  logic [RS_SIZE-1:0] busy_q, busy_d;
  logic [RS_SIZE-1:0] rj_q, rj_d, rk_q, rk_d;
  logic [INST_W-1:0]  inst_q [RS_SIZE];
  logic [INST_W-1:0]  inst_d [RS_SIZE];
  logic [31:0]        vj_q [RS_SIZE];
  logic [31:0]        vj_d [RS_SIZE];
  logic [31:0]        vk_q [RS_SIZE];
  logic [31:0]        vk_d [RS_SIZE];
  logic [TAG_W-1:0]   qj_q [RS_SIZE];
  logic [TAG_W-1:0]   qj_d [RS_SIZE];
  logic [TAG_W-1:0]   qk_q [RS_SIZE];
  logic [TAG_W-1:0]   qk_d [RS_SIZE];
  logic [31:0]        imm_q [RS_SIZE];
  logic [31:0]        imm_d [RS_SIZE];
  logic [31:0]        pc_q [RS_SIZE];
  logic [31:0]        pc_d [RS_SIZE];
  logic [TAG_W-1:0]   dest_q [RS_SIZE];
  logic [TAG_W-1:0]   dest_d [RS_SIZE];

  // Issue output registers
  logic              alu_valid_q, alu_valid_d;
  logic [INST_W-1:0] alu_inst_q, alu_inst_d;
  logic [31:0]       alu_op1_q, alu_op1_d;
  logic [31:0]       alu_op2_q, alu_op2_d;
  logic [31:0]       alu_imm_q, alu_imm_d;
  logic [31:0]       alu_pc_q, alu_pc_d;
  logic [TAG_W-1:0]  alu_dest_q, alu_dest_d;

  logic             all_busy;
  logic [IDX_W-1:0] ins_idx;
  logic             iss_found;
  logic [IDX_W-1:0] iss_idx;

  assign all_busy = &busy_q;
  // Held low during reset so the dispatcher never sees a stale full.
  assign full_out = rst & all_busy;

  // Lowest-index free slot and lowest-index ready entry. The loops run from
  // the top down, so the last assignment is the lowest index.
  always_comb begin
    ins_idx   = '0;
    iss_found = 1'b0;
    iss_idx   = '0;
    for (int i = RS_SIZE - 1; i >= 0; i--) begin
      if (!busy_q[i]) ins_idx = IDX_W'(i);
      if (busy_q[i] && rj_q[i] && rk_q[i]) begin
        iss_found = 1'b1;
        iss_idx   = IDX_W'(i);
      end
    end
  end

  always_comb begin
    busy_d = busy_q;  rj_d = rj_q;  rk_d = rk_q;
    inst_d = inst_q;  vj_d = vj_q;  vk_d = vk_q;
    qj_d   = qj_q;    qk_d = qk_q;  imm_d = imm_q;
    pc_d   = pc_q;    dest_d = dest_q;
    alu_valid_d = 1'b0;
    alu_inst_d  = alu_inst_q;
    alu_op1_d   = alu_op1_q;
    alu_op2_d   = alu_op2_q;
    alu_imm_d   = alu_imm_q;
    alu_pc_d    = alu_pc_q;
    alu_dest_d  = alu_dest_q;

    if (clear_in) begin
      busy_d = '0;
    end else begin
      // CDB wakeup. This only affects entries that are already present. A
      // woken entry becomes selectable on the following cycle.
      if (cdb_valid_in) begin
        for (int i = 0; i < RS_SIZE; i++) begin
          if (busy_q[i] && !rj_q[i] && (qj_q[i] == cdb_tag_in)) begin
            vj_d[i] = cdb_value_in;
            rj_d[i] = 1'b1;
          end
          if (busy_q[i] && !rk_q[i] && (qk_q[i] == cdb_tag_in)) begin
            vk_d[i] = cdb_value_in;
            rk_d[i] = 1'b1;
          end
        end
      end

      if (iss_found) begin
        busy_d[iss_idx] = 1'b0;
        alu_valid_d     = 1'b1;
        alu_inst_d      = inst_q[iss_idx];
        alu_op1_d       = vj_q[iss_idx];
        alu_op2_d       = vk_q[iss_idx];
        alu_imm_d       = imm_q[iss_idx];
        alu_pc_d        = pc_q[iss_idx];
        alu_dest_d      = dest_q[iss_idx];
      end

      // The insert slot is non-busy now and the issue slot is busy, so both
      // can never target the same entry in one cycle.
      if (new_inst_in && !all_busy) begin
        busy_d[ins_idx] = 1'b1;
        inst_d[ins_idx] = inst_in;
        imm_d[ins_idx]  = imm_in;
        pc_d[ins_idx]   = pc_in;
        dest_d[ins_idx] = dest_in;
        qj_d[ins_idx]   = rs1_tag_in;
        qk_d[ins_idx]   = rs2_tag_in;
        // A same-cycle CDB match bypasses straight into the operand value.
        if (!rs1_busy_in) begin
          vj_d[ins_idx] = rs1_val_in;   rj_d[ins_idx] = 1'b1;
        end else if (cdb_valid_in && (cdb_tag_in == rs1_tag_in)) begin
          vj_d[ins_idx] = cdb_value_in; rj_d[ins_idx] = 1'b1;
        end else begin
          rj_d[ins_idx] = 1'b0;
        end
        if (!rs2_busy_in) begin
          vk_d[ins_idx] = rs2_val_in;   rk_d[ins_idx] = 1'b1;
        end else if (cdb_valid_in && (cdb_tag_in == rs2_tag_in)) begin
          vk_d[ins_idx] = cdb_value_in; rk_d[ins_idx] = 1'b1;
        end else begin
          rk_d[ins_idx] = 1'b0;
        end
      end
    end
  end

  // Payload fields are not reset. They are only observed through an entry
  // whose busy flag is set.
  always_ff @(posedge clk) begin
    if (!rst) begin
      busy_q      <= '0;
      alu_valid_q <= 1'b0;
      alu_inst_q  <= '0;
      alu_op1_q   <= '0;
      alu_op2_q   <= '0;
      alu_imm_q   <= '0;
      alu_pc_q    <= '0;
      alu_dest_q  <= '0;
    end else begin
      busy_q      <= busy_d;
      rj_q        <= rj_d;
      rk_q        <= rk_d;
      inst_q      <= inst_d;
      vj_q        <= vj_d;
      vk_q        <= vk_d;
      qj_q        <= qj_d;
      qk_q        <= qk_d;
      imm_q       <= imm_d;
      pc_q        <= pc_d;
      dest_q      <= dest_d;
      alu_valid_q <= alu_valid_d;
      alu_inst_q  <= alu_inst_d;
      alu_op1_q   <= alu_op1_d;
      alu_op2_q   <= alu_op2_d;
      alu_imm_q   <= alu_imm_d;
      alu_pc_q    <= alu_pc_d;
      alu_dest_q  <= alu_dest_d;
    end
  end

  assign alu_valid_out = alu_valid_q;
  assign alu_inst_out  = alu_inst_q;
  assign alu_op1_out   = alu_op1_q;
  assign alu_op2_out   = alu_op2_q;
  assign alu_imm_out   = alu_imm_q;
  assign alu_pc_out    = alu_pc_q;
  assign alu_dest_out  = alu_dest_q;

endmodule

// File: tb/tb_reservation_station.sv
// ---------------------------------------------------------------------------
// tb_reservation_station
//   Directed bench for reservation_station (RS_SIZE=8, TAG_W=4, INST_W=6).
//   Each table row holds one cycle of inputs and the expected outputs after
//   that edge. The inst/imm/pc fields of every instruction are derived from
//   its dest tag. A short back-to-back sequence at the end uses an expected
//   queue.
// ---------------------------------------------------------------------------
module tb_reservation_station;

  logic        clk;
  logic        rst;
  logic        new_inst_in;
  logic [5:0]  inst_in;
  logic [31:0] imm_in, pc_in;
  logic [3:0]  dest_in;
  logic        rs1_busy_in, rs2_busy_in;
  logic [3:0]  rs1_tag_in, rs2_tag_in;
  logic [31:0] rs1_val_in, rs2_val_in;
  logic        cdb_valid_in;
  logic [3:0]  cdb_tag_in;
  logic [31:0] cdb_value_in;
  logic        clear_in;
  logic        full_out, alu_valid_out;
  logic [5:0]  alu_inst_out;
  logic [31:0] alu_op1_out, alu_op2_out, alu_imm_out, alu_pc_out;
  logic [3:0]  alu_dest_out;

  reservation_station #(.RS_SIZE(8), .TAG_W(4), .INST_W(6)) dut (
    .clk(clk), .rst(rst), .new_inst_in(new_inst_in), .inst_in(inst_in),
    .imm_in(imm_in), .pc_in(pc_in), .dest_in(dest_in),
    .rs1_busy_in(rs1_busy_in), .rs1_tag_in(rs1_tag_in), .rs1_val_in(rs1_val_in),
    .rs2_busy_in(rs2_busy_in), .rs2_tag_in(rs2_tag_in), .rs2_val_in(rs2_val_in),
    .cdb_valid_in(cdb_valid_in), .cdb_tag_in(cdb_tag_in), .cdb_value_in(cdb_value_in),
    .clear_in(clear_in), .full_out(full_out), .alu_valid_out(alu_valid_out),
    .alu_inst_out(alu_inst_out), .alu_op1_out(alu_op1_out), .alu_op2_out(alu_op2_out),
    .alu_imm_out(alu_imm_out), .alu_pc_out(alu_pc_out), .alu_dest_out(alu_dest_out)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        rst_n;
    logic        ins;
    logic [3:0]  dest;
    logic        b1;
    logic [3:0]  t1;
    logic [31:0] v1;
    logic        b2;
    logic [3:0]  t2;
    logic [31:0] v2;
    logic        cv;
    logic [3:0]  ct;
    logic [31:0] cval;
    logic        clr;
    logic        e_full;
    logic        e_valid;
    logic [31:0] e_op1;
    logic [31:0] e_op2;
    logic [3:0]  e_dest;
  } vec_t;

  vec_t        vecs[$];
  logic [31:0] exp_q[$];
  int          pass_cnt = 0;
  int          total_cnt = 0;

  // Expected ALU field values. These are held across idle cycles.
  logic [31:0] h_op1, h_op2, h_imm, h_pc;
  logic [5:0]  h_inst;
  logic [3:0]  h_dest;

  function automatic logic [5:0]  f_inst(logic [3:0] d); return {2'b00, d} + 6'd1; endfunction
  function automatic logic [31:0] f_imm(logic [3:0] d);  return 32'hA000_0000 | {28'b0, d}; endfunction
  function automatic logic [31:0] f_pc(logic [3:0] d);   return 32'h0000_1000 + {26'b0, d, 2'b00}; endfunction

  function automatic void add(string n, logic rn, logic ins, logic [3:0] d,
                              logic b1, logic [3:0] t1, logic [31:0] v1,
                              logic b2, logic [3:0] t2, logic [31:0] v2,
                              logic cv, logic [3:0] ct, logic [31:0] cval, logic clr,
                              logic ef, logic ev, logic [31:0] eo1, logic [31:0] eo2,
                              logic [3:0] ed);
    vec_t v;
    v.name = n; v.rst_n = rn; v.ins = ins; v.dest = d;
    v.b1 = b1; v.t1 = t1; v.v1 = v1; v.b2 = b2; v.t2 = t2; v.v2 = v2;
    v.cv = cv; v.ct = ct; v.cval = cval; v.clr = clr;
    v.e_full = ef; v.e_valid = ev; v.e_op1 = eo1; v.e_op2 = eo2; v.e_dest = ed;
    vecs.push_back(v);
  endfunction

  // Idle cycle that expects the given full/valid/issued fields.
  function automatic void idle(string n, logic ef, logic ev, logic [31:0] eo1,
                               logic [31:0] eo2, logic [3:0] ed);
    add(n, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, ef, ev, eo1, eo2, ed);
  endfunction

  // Insert with no CDB activity that expects no issue.
  function automatic void ins(string n, logic [3:0] d, logic b1, logic [3:0] t1,
                              logic [31:0] v1, logic b2, logic [3:0] t2,
                              logic [31:0] v2, logic ef);
    add(n, 1, 1, d, b1, t1, v1, b2, t2, v2, 0, 0, 0, 0, ef, 0, 0, 0, 0);
  endfunction

  // Scoreboard compare
  task automatic chk(string n, logic [31:0] act, logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", n, act, exp);
  endtask

  // Driver tasks
  task automatic drive(vec_t v);
    rst = v.rst_n; new_inst_in = v.ins; dest_in = v.dest;
    inst_in = f_inst(v.dest); imm_in = f_imm(v.dest); pc_in = f_pc(v.dest);
    rs1_busy_in = v.b1; rs1_tag_in = v.t1; rs1_val_in = v.v1;
    rs2_busy_in = v.b2; rs2_tag_in = v.t2; rs2_val_in = v.v2;
    cdb_valid_in = v.cv; cdb_tag_in = v.ct; cdb_value_in = v.cval;
    clear_in = v.clr;
  endtask

  task automatic drive_idle();
    vec_t v;
    v = '{name: "idle", default: '0};
    v.rst_n = 1'b1;
    drive(v);
  endtask

  task automatic check_fields(string n);
    chk({n, ".op1"},  alu_op1_out, h_op1);
    chk({n, ".op2"},  alu_op2_out, h_op2);
    chk({n, ".dest"}, 32'(alu_dest_out), 32'(h_dest));
    chk({n, ".inst"}, 32'(alu_inst_out), 32'(h_inst));
    chk({n, ".imm"},  alu_imm_out, h_imm);
    chk({n, ".pc"},   alu_pc_out, h_pc);
  endtask

  initial begin
    vec_t v;
    v = '{name: "init", default: '0};
    drive(v);
    h_op1 = '0; h_op2 = '0; h_imm = '0; h_pc = '0; h_inst = '0; h_dest = '0;

    // Reset, then a ready insert that issues one cycle later as a single pulse.
    add("reset", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    idle("post_reset", 0, 0, 0, 0, 0);
    ins("rdy_ins", 3, 0, 0, 5, 0, 0, 7, 0);
    idle("rdy_issue", 0, 1, 5, 7, 3);
    idle("rdy_single_pulse", 0, 0, 0, 0, 0);
    // CDB wakeup two cycles after insert. Issue follows the CDB edge.
    ins("wk_ins", 1, 1, 9, 0, 0, 0, 32'h22, 0);
    idle("wk_wait1", 0, 0, 0, 0, 0);
    idle("wk_wait2", 0, 0, 0, 0, 0);
    add("wk_cdb", 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 9, 32'h10, 0, 0, 0, 0, 0, 0);
    idle("wk_issue", 0, 1, 32'h10, 32'h22, 1);
    idle("wk_after", 0, 0, 0, 0, 0);
    // Same-cycle bypass into rs2.
    add("bp_ins", 1, 1, 2, 0, 0, 32'h33, 1, 4, 0, 1, 4, 32'hAB, 0, 0, 0, 0, 0, 0);
    idle("bp_issue", 0, 1, 32'h33, 32'hAB, 2);
    idle("bp_after", 0, 0, 0, 0, 0);
    // Fill all 8 entries. Entry i waits on rs1 tag i.
    for (int i = 0; i < 8; i++)
      ins($sformatf("fill%0d", i), 4'(8 + i), 1, 4'(i), 0, 0, 0, 32'h100 + i, (i == 7));
    ins("drop_when_full", 5, 0, 0, 32'h5, 0, 0, 32'h5, 1);
    add("full_cdb3", 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 3, 32'h77, 0, 1, 0, 0, 0, 0);
    idle("full_issue3", 0, 1, 32'h77, 32'h103, 11);
    ins("refill_slot", 6, 0, 0, 32'h66, 0, 0, 32'h67, 1);
    idle("refill_issue", 0, 1, 32'h66, 32'h67, 6);
    // Flush the leftovers. Then entries 2 and 5 wake on the same edge.
    add("flush_all", 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 6; i++)
      ins($sformatf("ord_ins%0d", i), 4'(i), 1, (i == 2 || i == 5) ? 4'd14 : 4'd13,
          0, 0, 0, 32'h200 + i, 0);
    add("ord_cdb", 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 14, 32'h55, 0, 0, 0, 0, 0, 0);
    idle("ord_issue2", 0, 1, 32'h55, 32'h202, 2);
    idle("ord_issue5", 0, 1, 32'h55, 32'h205, 5);
    idle("ord_after", 0, 0, 0, 0, 0);
    // Clear beats insert and wakeup in the same cycle.
    add("clr_ins_cdb", 1, 1, 7, 0, 0, 32'h70, 0, 0, 32'h71, 1, 13, 32'h99, 1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) idle($sformatf("clr_quiet%0d", i), 0, 0, 0, 0, 0);
    // Clear also beats a pending issue.
    ins("clr_ready_ins", 8, 0, 0, 32'h80, 0, 0, 32'h81, 0);
    add("clr_vs_issue", 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
    idle("clr_vs_issue_after", 0, 0, 0, 0, 0);
    // Reset mid-operation discards 3 pending entries plus one about to issue.
    ins("rs_p0", 9, 1, 1, 0, 0, 0, 32'h9, 0);
    ins("rs_p1", 10, 1, 2, 0, 0, 0, 32'hA, 0);
    ins("rs_p2", 11, 1, 3, 0, 0, 0, 32'hB, 0);
    ins("rs_ready", 12, 0, 0, 32'hC, 0, 0, 32'hC, 0);
    add("rst_mid", 0, 1, 13, 0, 0, 32'hD, 0, 0, 32'hD, 1, 1, 32'h11, 1, 0, 0, 0, 0, 0);
    add("rst_cdb2", 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2, 32'h22, 0, 0, 0, 0, 0, 0);
    idle("rst_quiet0", 0, 0, 0, 0, 0);
    idle("rst_quiet1", 0, 0, 0, 0, 0);

    foreach (vecs[i]) begin
      @(negedge clk);
      drive(vecs[i]);
      @(posedge clk);
      #1;
      chk({vecs[i].name, ".full"},  32'(full_out), 32'(vecs[i].e_full));
      chk({vecs[i].name, ".valid"}, 32'(alu_valid_out), 32'(vecs[i].e_valid));
      if (!vecs[i].rst_n) begin
        h_op1 = '0; h_op2 = '0; h_imm = '0; h_pc = '0; h_inst = '0; h_dest = '0;
      end else if (vecs[i].e_valid) begin
        h_op1  = vecs[i].e_op1;
        h_op2  = vecs[i].e_op2;
        h_dest = vecs[i].e_dest;
        h_inst = f_inst(vecs[i].e_dest);
        h_imm  = f_imm(vecs[i].e_dest);
        h_pc   = f_pc(vecs[i].e_dest);
      end
      check_fields(vecs[i].name);
    end

    // Back-to-back ready inserts. Each one issues on the next edge, and
    // freed slots are reused immediately.
    for (int k = 0; k < 5; k++) begin
      logic [31:0] e;
      @(negedge clk);
      if (k < 4) begin
        drive_idle();
        new_inst_in = 1'b1;
        dest_in = 4'(k + 1);
        inst_in = f_inst(4'(k + 1)); imm_in = f_imm(4'(k + 1)); pc_in = f_pc(4'(k + 1));
        rs1_val_in = 32'h40 + k; rs2_val_in = 32'h50 + k;
        exp_q.push_back(32'h40 + k);
      end else begin
        drive_idle();
      end
      @(posedge clk);
      #1;
      if (k == 0) begin
        chk("b2b_first_valid", 32'(alu_valid_out), 32'd0);
      end else begin
        e = exp_q.pop_front();
        chk($sformatf("b2b%0d.valid", k), 32'(alu_valid_out), 32'd1);
        chk($sformatf("b2b%0d.op1", k), alu_op1_out, e);
        chk($sformatf("b2b%0d.op2", k), alu_op2_out, e + 32'h10);
        chk($sformatf("b2b%0d.dest", k), 32'(alu_dest_out), 32'(e[3:0]) + 32'd1);
        chk($sformatf("b2b%0d.full", k), 32'(full_out), 32'd0);
      end
    end
    @(negedge clk);
    drive_idle();
    @(posedge clk);
    #1;
    chk("b2b_end_valid", 32'(alu_valid_out), 32'd0);
    chk("b2b_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/reservation_station.md
RESERVATION_STATION -- requirements
Module: reservation_station

Interface
REQ-001 Parameter RS_SIZE, default 8, number of entries.
REQ-002 Parameter TAG_W, default 4, ROB tag width.
REQ-003 Parameter INST_W, default 6, inner instruction type width.
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 rst  input  1  reset, synchronous, active-low: rst=0 at a rising edge resets the block.
REQ-006 new_inst_in  input  1  dispatcher pulse; the instruction fields are valid this cycle.
REQ-007 inst_in  input  INST_W  inner instruction type; imm_in input 32 immediate; pc_in input 32 instruction PC.
REQ-008 dest_in  input  TAG_W  ROB tag of the instruction.
REQ-009 rs1_busy_in  input  1  the rs1 operand is pending; rs1_tag_in input TAG_W producer tag; rs1_val_in input 32 value when not busy.
REQ-010 rs2_busy_in, rs2_tag_in, rs2_val_in  are the same as REQ-009, for rs2.
REQ-011 cdb_valid_in  input  1  broadcast valid; cdb_tag_in input TAG_W; cdb_value_in input 32.
REQ-012 clear_in  input  1  ROB misprediction flush.
REQ-013 full_out  output  1  all entries are busy.
REQ-014 alu_valid_out  output  1  issue pulse to the ALU.
REQ-015 alu_inst_out INST_W, alu_op1_out 32, alu_op2_out 32, alu_imm_out 32, alu_pc_out 32, alu_dest_out TAG_W  are all outputs carrying the issued instruction's fields.

Function
REQ-016 Each entry SHALL hold: busy, inst, Vj, Vk, Qj, Qk, Rj, Rk (operand-ready flags), imm, pc, dest.
REQ-017 If new_inst_in=1 and full_out=0, the block SHALL write the lowest-index non-busy entry and set its busy flag at the edge.
REQ-018 If new_inst_in=1 while full_out=1, the block SHALL drop the instruction and change no state.
REQ-019 Operand capture at insert: if busy_in=0, the operand SHALL be V=val_in, R=1.
REQ-020 Operand capture at insert: if busy_in=1 and cdb_valid_in=1 with cdb_tag_in==tag_in, the operand SHALL be V=cdb_value_in, R=1 (same-cycle bypass).
REQ-021 Operand capture at insert: otherwise the operand SHALL be Q=tag_in, R=0.
REQ-022 Wakeup: at each edge with cdb_valid_in=1, every busy entry with R=0 and Q==cdb_tag_in SHALL set V=cdb_value_in and R=1, for Qj and Qk independently.
REQ-023 Issue selection SHALL be combinational from the current state: the lowest-index entry with busy=1, Rj=1 and Rk=1.
REQ-024 If a candidate exists, the block SHALL register the ALU outputs from that entry, set alu_valid_out=1, and clear the entry's busy flag at the same edge.
REQ-025 If no candidate exists, alu_valid_out SHALL be 0 at the next edge and the other alu_* outputs SHALL hold their values.
REQ-026 The block SHALL issue at most one instruction per cycle; alu_valid_out SHALL be a single-cycle pulse per issued instruction.
REQ-027 Latency: an instruction inserted with both operands ready at edge E SHALL issue at edge E+1 (alu_valid_out high in the cycle after E+1).
REQ-028 An entry woken by the CDB at edge E SHALL be eligible for issue at edge E+1 and no earlier.
REQ-029 A slot freed by issue at edge E SHALL be reusable for insertion from edge E+1.
REQ-030 The same slot SHALL NOT be both issued and inserted at one edge.
REQ-031 full_out SHALL be combinational: the AND of all busy flags.
REQ-032 The dispatcher SHALL keep new_inst_in low whenever full_out is high.
REQ-033 clear_in=1 at an edge SHALL clear every busy flag and set alu_valid_out=0.
REQ-034 clear_in SHALL take priority over insert, issue and wakeup in that cycle.
REQ-035 Tags SHALL be compared at full TAG_W width; there is no reserved tag value.

Reset
REQ-036 On rst=0 at an edge, the block SHALL clear all busy flags and set alu_valid_out=0 and alu_inst_out, alu_op1_out, alu_op2_out, alu_imm_out, alu_pc_out, alu_dest_out to 0.
REQ-037 While rst=0, full_out SHALL be 0, and new_inst_in, cdb_valid_in and clear_in SHALL be ignored.
REQ-038 rst SHALL take priority over clear_in.
REQ-039 A reset asserted mid-operation SHALL discard pending entries without issuing them.

Verification
REQ-040 Ready insert: insert ADD, rs1_val=5, rs2_val=7, dest=3, no busy -> alu_valid_out=1 one cycle later with op1=5, op2=7, dest=3, single pulse.
REQ-041 Wakeup: insert with rs1_busy=1, tag=9; CDB tag=9, value=0x10 two cycles later -> issue on the edge after the CDB edge with op1=0x10; no issue before it.
REQ-042 Bypass: insert with rs2_busy=1, tag=4, and cdb_valid=1, tag=4, value=0xAB in the same cycle -> next-edge issue with op2=0xAB.
REQ-043 Full/drop: fill 8 entries with pending operands -> full_out=1; a 9th insert is dropped; broadcast the tag to one entry -> issue, full_out=0 the next cycle, and the following insert lands in the freed slot.
REQ-044 Ordering: entries 2 and 5 become ready at the same edge -> entry 2 issues first, entry 5 the next cycle.
REQ-045 Flush/reset: with 3 entries pending, clear_in=1 (or rst=0) together with new_inst_in=1 -> all entries empty, alu_valid_out=0, the new instruction is not stored, and no later issue occurs.
